rf_wb_arbiter: RTL and testbench

Write-back arbiter for the single register-file write port. Two producers share that port: source A, the in-order pipeline write-back, and source B, the multicycle unit (mult/div, late loads). Each producer has a one-entry holding slot behind a valid/ready handshake. The arbiter retires buffered writes oldest-first, drives the register file's WEN/wsel/wdat from registered outputs, and reports pending destinations to the hazard unit.

---
 rtl/cpu_types_pkg.sv | 27 ++
 rtl/wb_slot.sv | 33 +++
 rtl/rf_wb_arbiter.sv | 96 +++++++++
 tb/tb_rf_wb_arbiter.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// rtl/cpu_types_pkg.sv - shared CPU datapath types, including write-back arbiter types
package cpu_types_pkg;

  typedef logic [31:0] word_t;
  typedef logic [4:0]  regbits_t;

  typedef struct packed {
    regbits_t sel;
    word_t    dat;
  } wb_req_t;

  typedef enum logic [2:0] {
    EMPTY,
    A_ONLY,
    B_ONLY,
    BOTH_A_OLD,
    BOTH_B_OLD
  } wbarb_state_t;

  function automatic word_t reg_decode(input regbits_t r);
    word_t m;
    m    = '0;
    m[r] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/wb_slot.sv
// rtl/wb_slot.sv - one-entry write-back holding slot with valid/ready handshake
module wb_slot
  import cpu_types_pkg::*;
(
  input  logic    CLK,
  input  logic    RST,
  input  logic    in_valid,
  output logic    in_ready,
  input  wb_req_t in_req,
  input  logic    grant,
  output logic    valid,
  output wb_req_t req
);

  logic load;

  // A granted slot frees up this cycle, so it may refill on the same edge.
  assign in_ready = !RST && (!valid || grant);
  assign load     = in_valid && in_ready;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      valid <= 1'b0;
      req   <= '0;
    end else if (load) begin
      valid <= 1'b1;
      req   <= in_req;
    end else if (grant) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/rf_wb_arbiter.sv
// rtl/rf_wb_arbiter.sv - oldest-first arbiter for the single register-file write port
module rf_wb_arbiter
  import cpu_types_pkg::*;
#(
  parameter int NSRC = 2
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        a_valid,
  output logic        a_ready,
  input  logic [4:0]  a_sel,
  input  logic [31:0] a_dat,
  input  logic        b_valid,
  output logic        b_ready,
  input  logic [4:0]  b_sel,
  input  logic [31:0] b_dat,
  output logic        rf_wen,
  output logic [4:0]  rf_wsel,
  output logic [31:0] rf_wdat,
  output logic [31:0] pend_mask
);

  wbarb_state_t     state, state_nxt;
  logic [NSRC-1:0]  grant;
  logic             a_held, b_held;
  wb_req_t          a_in, b_in, a_req, b_req;
  logic             a_keep, b_keep, a_load, b_load;

  assign a_in = '{sel: a_sel, dat: a_dat};
  assign b_in = '{sel: b_sel, dat: b_dat};

  wb_slot u_slot_a (
    .CLK(CLK), .RST(RST), .in_valid(a_valid), .in_ready(a_ready), .in_req(a_in),
    .grant(grant[0]), .valid(a_held), .req(a_req)
  );

  wb_slot u_slot_b (
    .CLK(CLK), .RST(RST), .in_valid(b_valid), .in_ready(b_ready), .in_req(b_in),
    .grant(grant[1]), .valid(b_held), .req(b_req)
  );

  assign grant[0] = (state == A_ONLY) || (state == BOTH_A_OLD);
  assign grant[1] = (state == B_ONLY) || (state == BOTH_B_OLD);

  assign a_keep = a_held && !grant[0];
  assign b_keep = b_held && !grant[1];
  assign a_load = a_valid && a_ready;
  assign b_load = b_valid && b_ready;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= EMPTY;
    else     state <= state_nxt;
  end

  // A held slot is always older than a fresh load; simultaneous loads put B first.
  always_comb begin
    state_nxt = EMPTY;
    if ((a_keep || a_load) && (b_keep || b_load)) begin
      if (a_keep && !b_keep)      state_nxt = BOTH_A_OLD;
      else if (b_keep && !a_keep) state_nxt = BOTH_B_OLD;
      else if (a_keep && b_keep)  state_nxt = state;
      else                        state_nxt = BOTH_B_OLD;
    end else if (a_keep || a_load) begin
      state_nxt = A_ONLY;
    end else if (b_keep || b_load) begin
      state_nxt = B_ONLY;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rf_wen  <= 1'b0;
      rf_wsel <= '0;
      rf_wdat <= '0;
    end else if (grant[0]) begin
      rf_wen  <= (a_req.sel != '0);
      rf_wsel <= a_req.sel;
      rf_wdat <= a_req.dat;
    end else if (grant[1]) begin
      rf_wen  <= (b_req.sel != '0);
      rf_wsel <= b_req.sel;
      rf_wdat <= b_req.dat;
    end else begin
      rf_wen  <= 1'b0;
    end
  end

  always_comb begin
    pend_mask = '0;
    if (a_held) pend_mask = pend_mask | reg_decode(a_req.sel);
    if (b_held) pend_mask = pend_mask | reg_decode(b_req.sel);
    if (rf_wen) pend_mask = pend_mask | reg_decode(rf_wsel);
    pend_mask[0] = 1'b0;
  end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// tb/tb_rf_wb_arbiter.sv - scoreboard bench for the write-back arbiter
module tb_rf_wb_arbiter;

  typedef struct packed {
    logic [4:0]  sel;
    logic [31:0] dat;
  } exp_t;

  logic        CLK = 1'b0;
  logic        RST;
  logic        a_valid, b_valid, a_ready, b_ready;
  logic [4:0]  a_sel, b_sel, rf_wsel;
  logic [31:0] a_dat, b_dat, rf_wdat, pend_mask;
  logic        rf_wen;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_err    = 0;

  rf_wb_arbiter #(.NSRC(2)) dut (
    .CLK(CLK), .RST(RST),
    .a_valid(a_valid), .a_ready(a_ready), .a_sel(a_sel), .a_dat(a_dat),
    .b_valid(b_valid), .b_ready(b_ready), .b_sel(b_sel), .b_dat(b_dat),
    .rf_wen(rf_wen), .rf_wsel(rf_wsel), .rf_wdat(rf_wdat), .pend_mask(pend_mask)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%h expected 0x%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic [4:0] sel, input logic [31:0] dat);
    exp_t e;
    e.sel = sel;
    e.dat = dat;
    exp_q.push_back(e);
  endtask

  // Called at a negedge; presents one cycle of stimulus and returns at the next negedge.
  task automatic step(input logic av, input logic [4:0] asel, input logic [31:0] adat,
                      input logic bv, input logic [4:0] bsel, input logic [31:0] bdat);
    a_valid = av; a_sel = asel; a_dat = adat;
    b_valid = bv; b_sel = bsel; b_dat = bdat;
    #1;
    if (av) chk("a_accept", {31'b0, a_ready}, 32'd1);
    if (bv) chk("b_accept", {31'b0, b_ready}, 32'd1);
    @(posedge CLK);
    @(negedge CLK);
    a_valid = 1'b0;
    b_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
  endtask

  always @(negedge CLK) begin
    if (!RST && rf_wen) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_err++;
        $display("FAIL unexpected_write: got r%0d=0x%h expected no write at %0t", rf_wsel, rf_wdat, $time);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("wb_sel", {27'b0, rf_wsel}, {27'b0, e.sel});
        chk("wb_dat", rf_wdat, e.dat);
      end
    end
  end

  initial begin
    int na, nb, sa, sb, max_sa, max_sb, cyc;
    logic ra, rb;

    RST = 1'b1;
    a_valid = 1'b0; b_valid = 1'b0;
    a_sel = '0; b_sel = '0; a_dat = '0; b_dat = '0;
    #1;
    chk("rst_wen",     {31'b0, rf_wen}, 32'd0);
    chk("rst_wsel",    {27'b0, rf_wsel}, 32'd0);
    chk("rst_wdat",    rf_wdat, 32'd0);
    chk("rst_pend",    pend_mask, 32'd0);
    chk("rst_a_ready", {31'b0, a_ready}, 32'd0);
    chk("rst_b_ready", {31'b0, b_ready}, 32'd0);
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    @(posedge CLK);
    @(negedge CLK);
    chk("post_rst_a_ready", {31'b0, a_ready}, 32'd1);
    chk("post_rst_b_ready", {31'b0, b_ready}, 32'd1);

    // single uncontended write with pend_mask window
    push(5'd5, 32'hDEADBEEF);
    step(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0);
    chk("single_pend_slot", pend_mask, 32'h0000_0020);
    chk("single_wen_early", {31'b0, rf_wen}, 32'd0);
    @(negedge CLK);
    chk("single_pend_out",  pend_mask, 32'h0000_0020);
    chk("single_wen",       {31'b0, rf_wen}, 32'd1);
    @(negedge CLK);
    chk("single_pend_clr",  pend_mask, 32'd0);
    chk("single_wen_clr",   {31'b0, rf_wen}, 32'd0);

    // same-edge tie to r3: B first
    push(5'd3, 32'h2);
    push(5'd3, 32'h1);
    step(1'b1, 5'd3, 32'h1, 1'b1, 5'd3, 32'h2);
    chk("tie_b_ready", {31'b0, b_ready}, 32'd1);
    chk("tie_a_ready", {31'b0, a_ready}, 32'd0);
    idle(3);

    // oldest-first while the port is busy
    push(5'd2, 32'h22);
    push(5'd1, 32'h11);
    push(5'd7, 32'hB);
    push(5'd7, 32'hA);
    step(1'b1, 5'd1, 32'h11, 1'b1, 5'd2, 32'h22);
    step(1'b0, 5'd0, 32'h0,  1'b1, 5'd7, 32'hB);
    step(1'b1, 5'd7, 32'hA,  1'b0, 5'd0, 32'h0);
    idle(4);

    // write to r0 is accepted and dropped
    step(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'hFFFF);
    for (int i = 0; i < 3; i++) begin
      chk("r0_wen",  {31'b0, rf_wen}, 32'd0);
      chk("r0_pend", pend_mask, 32'd0);
      @(negedge CLK);
    end

    // saturation: expected order B0,A0,B1,A1,...
    for (int i = 0; i < 10; i++) begin
      push(5'(16 + i), 32'hB000 + i);
      push(5'(1 + i),  32'hA000 + i);
    end
    na = 0; nb = 0; sa = 0; sb = 0; max_sa = 0; max_sb = 0; cyc = 0;
    while ((na < 10 || nb < 10) && cyc < 60) begin
      a_valid = (na < 10); a_sel = 5'(1 + na);  a_dat = 32'hA000 + na;
      b_valid = (nb < 10); b_sel = 5'(16 + nb); b_dat = 32'hB000 + nb;
      #1;
      ra = a_ready; rb = b_ready;
      if (a_valid && !ra) sa++; else sa = 0;
      if (b_valid && !rb) sb++; else sb = 0;
      if (sa > max_sa) max_sa = sa;
      if (sb > max_sb) max_sb = sb;
      @(posedge CLK);
      if (a_valid && ra) na++;
      if (b_valid && rb) nb++;
      @(negedge CLK);
      cyc++;
    end
    a_valid = 1'b0; b_valid = 1'b0;
    chk("sat_a_accepts", na, 32'd10);
    chk("sat_b_accepts", nb, 32'd10);
    chk("sat_cycles", cyc, 32'd19);
    chk("sat_a_max_stall", max_sa, 32'd1);
    chk("sat_b_max_stall", max_sb, 32'd1);
    idle(4);

    // reset with both slots full discards them
    step(1'b1, 5'd10, 32'hAAAA, 1'b1, 5'd11, 32'hBBBB);
    chk("pre_rst_pend", pend_mask, 32'h0000_0C00);
    RST = 1'b1;
    #1;
    chk("mid_rst_wen",     {31'b0, rf_wen}, 32'd0);
    chk("mid_rst_pend",    pend_mask, 32'd0);
    chk("mid_rst_a_ready", {31'b0, a_ready}, 32'd0);
    chk("mid_rst_b_ready", {31'b0, b_ready}, 32'd0);
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    @(posedge CLK);
    @(negedge CLK);
    chk("rel_a_ready", {31'b0, a_ready}, 32'd1);
    chk("rel_b_ready", {31'b0, b_ready}, 32'd1);
    idle(4);
    chk("rel_pend", pend_mask, 32'd0);

    chk("queue_drained", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
